jtag_host_sequencer: RTL and testbench
======================================

# jtag_host_sequencer

Embedded JTAG host engine that drives the TAP of the `jtag` block from the internal clock domain. It accepts high-level commands (test-logic-reset, IR scan, DR scan, idle cycles), generates the TCK/TMS/TDI waveforms and returns captured TDO bits. It replaces hand-written TMS sequences for on-chip self-test of IDCODE, BYPASS, SAMPLE and EXTEST.

## Interface
- CLK_DIV, 20, TCK half-period in internal_clk cycles; legal values are 1 or more.
- MAX_LEN, 32, maximum shift length; larger cmd_len values are clamped to MAX_LEN.
- internal_clk  in  1  sole clock; all logic on its rising edge.
- internal_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  command opcode:
  - 0 = TLR (test-logic-reset).
  - 1 = IR scan.
  - 2 = DR scan.
  - 3 = IDLE.
- cmd_len  in  6  shift length for scans, or TCK count for IDLE.
- cmd_data  in  32  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  32  captured TDO bits, LSB first; unshifted bits are 0.
- jtag_clk  out  1  TCK to the TAP.
- jtag_mode  out  1  TMS.
- jtag_digital_input  out  1  TDI.
- jtag_digital_output  in  1  TDO.

## Operation
- States:
  - ST_IDLE: no command in progress.
  - ST_PRE: header TMS bits.
  - ST_SHIFT: data bits.
  - ST_POST: trailer TMS bits.
  - ST_RESP: completion cycle.
- cmd_ready is 1 only in ST_IDLE. A command is accepted when cmd_valid and cmd_ready are both 1; op, len and data are latched at acceptance.
- All sequences start and end in Run-Test/Idle, except TLR, which may start from any TAP state.
- TMS sequences per TCK bit (N = clamped length):
  - TLR: 1,1,1,1,1,0. 6 bits, all in ST_PRE.
  - IR scan: PRE 1,1,0,0; SHIFT N bits with TMS 0 except the last bit, which has TMS 1; POST 1,0. Total N+6 bits.
  - DR scan: PRE 1,0,0; SHIFT as for IR; POST 1,0. Total N+5 bits.
  - Scan with N=0: skip ST_SHIFT. The last PRE bit is 1 instead of 0, giving Capture → Exit1. DR: 1,0,1,1,0. IR: 1,1,0,1,1,0.
  - IDLE: N bits, all TMS 0. N=0 goes straight to ST_RESP.
- TDI:
  - During shift bit i, TDI = cmd_data[i].
  - Outside ST_SHIFT, TDI = 0.
- TDO:
  - Sampled on the internal_clk cycle in which jtag_clk rises, for shift bits only.
  - Stored as rsp_data[i] = TDO.
- rsp_data for TLR and IDLE is 0. rsp_data holds its value until the next command's rsp_valid.

## Timing
- TCK is gated: jtag_clk stays low in ST_IDLE and ST_RESP.
- Each TCK bit lasts 2·CLK_DIV cycles: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
- Acceptance at cycle t:
  - TMS/TDI of bit 0 are valid from t+1, with jtag_clk low.
  - jtag_clk rises at t+1+CLK_DIV.
  - jtag_clk falls at t+1+2·CLK_DIV; TMS/TDI of the next bit update in the same cycle.
  - TMS/TDI change only on falling TCK, so they are stable across each rising edge.
- Completion:
  - With B total bits, rsp_valid pulses at cycle t+1+2·CLK_DIV·B.
  - cmd_ready returns to 1 in the cycle after rsp_valid, so a new command can be accepted at t+2+2·CLK_DIV·B.
- Reset values:
  - jtag_clk = 0, jtag_mode = 0, jtag_digital_input = 0.
  - rsp_valid = 0, rsp_data = 0, cmd_ready = 0.
  - cmd_ready becomes 1 in the first cycle after internal_rst deasserts.
- Reset mid-command: abort immediately, drive outputs to reset values, produce no rsp_valid. The TAP state is then undefined, and software must issue TLR.
- cmd_valid while busy is ignored; it is not queued.

## Test plan
- Bench setup: CLK_DIV=2 and a behavioural TAP model with IDCODE 0x1234_5678 and BYPASS at IR 0xF.
- IDCODE read: TLR, then IR scan N=4 data 0x0, then DR scan N=32 data 0 → DR rsp_data = 0x12345678. IR scan rsp_data[1:0] = 2'b01 (capture pattern).
- BYPASS: TLR, IR scan N=4 data 0xF, DR scan N=4 data 4'b1010 → rsp_data = 0x4.
- Cycle count: DR scan N=4 accepted at t → 9 TCK rising edges, rsp_valid at exactly t+37, cmd_ready high at t+38. TLR → 6 rising edges with TMS 1,1,1,1,1,0.
- Zero-length DR scan (N=0) → TMS 1,0,1,1,0, TDI held 0, rsp_data = 0. IDLE N=0 → rsp_valid at t+1 with no TCK edges.
- Clamp and back-to-back: DR scan N=40 → exactly 32 shift bits. With cmd_valid held high, the second command is accepted the cycle after the first rsp_valid.
- Reset mid-op: assert internal_rst during shift bit 10 of a 32-bit DR scan → next cycle all outputs at reset values, no rsp_valid. A following TLR + IDCODE read still returns 0x12345678.

Source files
------------

// File: rtl/jtag_host_sequencer.sv
// ---------------------------------------------------------------------------
// jtag_host_sequencer
//
// Embedded JTAG host engine. Accepts high-level commands (test-logic-reset,
// IR scan, DR scan, idle clocks), generates TCK/TMS/TDI for an external TAP
// and returns the TDO bits captured during the shift phase.
//
// Parameters:
//   CLK_DIV  TCK half-period in internal_clk cycles (>= 1)
//   MAX_LEN  maximum shift length; longer cmd_len values are clamped
//
// Ports:
//   internal_clk         sole clock, rising edge
//   internal_rst         synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only when idle)
//   cmd_op               0=TLR, 1=IR scan, 2=DR scan, 3=IDLE
//   cmd_len              shift length, or TCK count for IDLE
//   cmd_data             TDI bits, LSB shifted first
//   rsp_valid            one-cycle completion pulse
//   rsp_data             captured TDO bits, LSB first, held until next pulse
//   jtag_clk             TCK (gated low when idle)
//   jtag_mode            TMS
//   jtag_digital_input   TDI
//   jtag_digital_output  TDO
// ---------------------------------------------------------------------------
module jtag_host_sequencer #(
    parameter int CLK_DIV = 20,
    parameter int MAX_LEN = 32
) (
    input  logic        internal_clk,
    input  logic        internal_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        jtag_clk,
    output logic        jtag_mode,
    output logic        jtag_digital_input,
    input  logic        jtag_digital_output
);

    localparam logic [1:0]  OP_TLR   = 2'd0;
    localparam logic [1:0]  OP_IR    = 2'd1;
    localparam logic [1:0]  OP_DR    = 2'd2;
    localparam logic [1:0]  OP_IDLE  = 2'd3;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [5:0]  LEN_MAX  = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [5:0]  r_len;
    logic [31:0] r_data;
    logic [31:0] r_cap;
    logic [15:0] r_div;
    logic        r_tck;
    logic [4:0]  r_idx;
    logic        r_tms;
    logic        r_tdi;
    logic        r_ready;
    logic        r_rspValid;
    logic [31:0] r_rspData;

    logic [5:0]  w_lenClamp;
    logic [5:0]  w_idxNext;
    logic [5:0]  w_preLen;

    // Number of header bits spent in ST_PRE. IDLE commands run all of their
    // TCK cycles here because they carry no data and never enter Shift.
    function automatic logic [5:0] preLen(input logic [1:0] op, input logic [5:0] len);
        logic [5:0] n;
        case (op)
            OP_TLR:  n = 6'd6;
            OP_IR:   n = 6'd4;
            OP_DR:   n = 6'd3;
            default: n = len;
        endcase
        return n;
    endfunction

    // TMS of header bit idx. A zero-length scan turns the last header bit
    // into a 1 so the TAP goes Capture -> Exit1 without shifting.
    function automatic logic preTms(input logic [1:0] op, input logic [5:0] len,
                                    input logic [5:0] idx);
        logic tms;
        case (op)
            OP_TLR:  tms = (idx != 6'd5);
            OP_IR:   tms = (idx < 6'd2) || ((idx == 6'd3) && (len == 6'd0));
            OP_DR:   tms = (idx == 6'd0) || ((idx == 6'd2) && (len == 6'd0));
            default: tms = 1'b0;
        endcase
        return tms;
    endfunction

    assign w_lenClamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign w_idxNext  = {1'b0, r_idx} + 6'd1;
    assign w_preLen   = preLen(r_op, r_len);

    // Sequencer. Each TCK bit is a low phase then a high phase of CLK_DIV
    // cycles. TDO is captured on the edge that raises TCK; TMS/TDI for the
    // next bit are loaded on the edge that lowers it, so they are stable
    // across every rising TCK edge.
    always_ff @(posedge internal_clk) begin
        if (internal_rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_TLR;
            r_len      <= '0;
            r_data     <= '0;
            r_cap      <= '0;
            r_div      <= '0;
            r_tck      <= 1'b0;
            r_idx      <= '0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
            r_ready    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rspValid <= 1'b0;
                    if (cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= cmd_op;
                        r_len   <= w_lenClamp;
                        r_data  <= cmd_data;
                        r_cap   <= '0;
                        r_div   <= '0;
                        r_tck   <= 1'b0;
                        r_idx   <= '0;
                        r_tdi   <= 1'b0;
                        if ((cmd_op == OP_IDLE) && (w_lenClamp == 6'd0)) begin
                            r_state    <= ST_RESP;
                            r_rspValid <= 1'b1;
                            r_rspData  <= '0;
                            r_tms      <= 1'b0;
                        end else begin
                            r_state <= ST_PRE;
                            r_tms   <= preTms(cmd_op, w_lenClamp, 6'd0);
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                ST_RESP: begin
                    r_rspValid <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 16'd1;
                    end else begin
                        r_div <= '0;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            if (r_state == ST_SHIFT) begin
                                r_cap[r_idx] <= jtag_digital_output;
                            end
                        end else begin
                            r_tck <= 1'b0;
                            case (r_state)
                                ST_PRE: begin
                                    if (w_idxNext < w_preLen) begin
                                        r_idx <= w_idxNext[4:0];
                                        r_tms <= preTms(r_op, r_len, w_idxNext);
                                    end else if ((r_op == OP_TLR) || (r_op == OP_IDLE)) begin
                                        r_state    <= ST_RESP;
                                        r_tms      <= 1'b0;
                                        r_tdi      <= 1'b0;
                                        r_rspValid <= 1'b1;
                                        r_rspData  <= r_cap;
                                    end else if (r_len == 6'd0) begin
                                        r_state <= ST_POST;
                                        r_idx   <= '0;
                                        r_tms   <= 1'b1;
                                    end else begin
                                        r_state <= ST_SHIFT;
                                        r_idx   <= '0;
                                        r_tms   <= (r_len == 6'd1);
                                        r_tdi   <= r_data[0];
                                    end
                                end
                                ST_SHIFT: begin
                                    if (w_idxNext < r_len) begin
                                        r_idx <= w_idxNext[4:0];
                                        r_tms <= (w_idxNext == (r_len - 6'd1));
                                        r_tdi <= r_data[w_idxNext[4:0]];
                                    end else begin
                                        r_state <= ST_POST;
                                        r_idx   <= '0;
                                        r_tms   <= 1'b1;
                                        r_tdi   <= 1'b0;
                                    end
                                end
                                default: begin
                                    if (r_idx == 5'd0) begin
                                        r_idx <= 5'd1;
                                        r_tms <= 1'b0;
                                    end else begin
                                        r_state    <= ST_RESP;
                                        r_tms      <= 1'b0;
                                        r_tdi      <= 1'b0;
                                        r_rspValid <= 1'b1;
                                        r_rspData  <= r_cap;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready          = r_ready;
    assign rsp_valid          = r_rspValid;
    assign rsp_data           = r_rspData;
    assign jtag_clk           = r_tck;
    assign jtag_mode          = r_tms;
    assign jtag_digital_input = r_tdi;

endmodule

// File: tb/tb_jtag_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jtag_host_sequencer
//
// Drives jtag_host_sequencer (CLK_DIV=2) against a behavioural TAP with
// IDCODE 0x12345678 at IR 0x0 and BYPASS elsewhere (0xF used). A command-
// level model predicts every output cycle from the sequence rules; directed
// scenarios add literal expectations, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_jtag_host_sequencer;

    localparam int CD = 2;
    localparam logic [31:0] IDCODE = 32'h1234_5678;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic [1:0]  cmdOp = 2'd0;
    logic [5:0]  cmdLen = 6'd0;
    logic [31:0] cmdData = 32'd0;
    logic        cmdReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    jtag_host_sequencer #(.CLK_DIV(CD), .MAX_LEN(32)) dut (
        .internal_clk        (clock),
        .internal_rst        (reset),
        .cmd_valid           (cmdValid),
        .cmd_ready           (cmdReady),
        .cmd_op              (cmdOp),
        .cmd_len             (cmdLen),
        .cmd_data            (cmdData),
        .rsp_valid           (rspValid),
        .rsp_data            (rspData),
        .jtag_clk            (tck),
        .jtag_mode           (tms),
        .jtag_digital_input  (tdi),
        .jtag_digital_output (tdo)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural TAP ----------------
    typedef enum int {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPIR
    } tap_t;

    function automatic tap_t tapNext(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PAUDR;
            T_PAUDR: return m ? T_EX2DR : T_PAUDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAUIR;
            T_PAUIR: return m ? T_EX2IR : T_PAUIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    tap_t        tapSt = T_TLR;
    logic [3:0]  ir = 4'h0;
    logic [3:0]  irSr = 4'h0;
    logic [31:0] drSr = 32'h0;

    always @(posedge tck) begin
        case (tapSt)
            T_TLR:   ir <= 4'h0;
            T_CAPIR: irSr <= 4'b0001;
            T_SHIR:  irSr <= {tdi, irSr[3:1]};
            T_UPIR:  ir <= irSr;
            T_CAPDR: drSr <= (ir == 4'h0) ? IDCODE : 32'h0;
            T_SHDR: begin
                if (ir == 4'h0) drSr <= {tdi, drSr[31:1]};
                else            drSr[0] <= tdi;
            end
            default: ;
        endcase
        tapSt <= tapNext(tapSt, tms);
    end

    always @(negedge tck) begin
        tdo <= (tapSt == T_SHDR) ? drSr[0] : ((tapSt == T_SHIR) ? irSr[0] : 1'b0);
    end

    // TMS/TDI seen at each rising TCK edge
    bit tmsRise[$];
    bit tdiRise[$];
    always @(posedge tck) begin
        tmsRise.push_back(tms);
        tdiRise.push_back(tdi);
    end

    // ---------------- command-level model ----------------
    // Builds the complete per-bit TMS/TDI list for a command straight from
    // the sequence rules; timing follows from bit index * 2*CD.
    function automatic void makeSeq(input logic [1:0] op, input int len, input logic [31:0] d,
                                    output logic [63:0] tv, output logic [63:0] dv,
                                    output int nb, output int sh, output int ns);
        bit tq[$];
        bit dq[$];
        int n;
        n = (len > 32) ? 32 : len;
        sh = 0;
        ns = 0;
        case (op)
            2'd0: tq = '{1, 1, 1, 1, 1, 0};
            2'd1: if (n == 0) tq = '{1, 1, 0, 1, 1, 0}; else tq = '{1, 1, 0, 0};
            2'd2: if (n == 0) tq = '{1, 0, 1, 1, 0};    else tq = '{1, 0, 0};
            default: for (int i = 0; i < n; i++) tq.push_back(1'b0);
        endcase
        for (int i = 0; i < tq.size(); i++) dq.push_back(1'b0);
        if ((op == 2'd1 || op == 2'd2) && n > 0) begin
            sh = tq.size();
            ns = n;
            for (int i = 0; i < n; i++) begin
                tq.push_back(i == n - 1);
                dq.push_back(d[i]);
            end
            tq.push_back(1'b1); dq.push_back(1'b0);
            tq.push_back(1'b0); dq.push_back(1'b0);
        end
        tv = '0;
        dv = '0;
        nb = tq.size();
        for (int i = 0; i < nb; i++) begin
            tv[i] = tq[i];
            dv[i] = dq[i];
        end
    endfunction

    bit          modelOn = 1'b0;
    bit          mBusy = 1'b0;
    bit          mReady = 1'b0;
    int          mK = 0;
    int          mB = 0;
    int          mSh = 0;
    int          mNs = 0;
    logic [63:0] mTms = '0;
    logic [63:0] mTdi = '0;
    logic [31:0] mCap = '0;
    logic [31:0] mRspData = '0;

    // Model state advances on each clock; mK counts cycles since acceptance
    // (1 = first cycle of bit 0).
    always @(posedge clock) begin : model
        logic [63:0] tv;
        logic [63:0] dv;
        int nb, sh, ns, kn, bn, pn;
        if (reset) begin
            modelOn  <= 1'b1;
            mBusy    <= 1'b0;
            mReady   <= 1'b0;
            mK       <= 0;
            mCap     <= '0;
            mRspData <= '0;
        end else if (!mBusy) begin
            if (cmdValid && mReady) begin
                makeSeq(cmdOp, int'(cmdLen), cmdData, tv, dv, nb, sh, ns);
                mTms   <= tv;
                mTdi   <= dv;
                mB     <= nb;
                mSh    <= sh;
                mNs    <= ns;
                mBusy  <= 1'b1;
                mK     <= 1;
                mReady <= 1'b0;
                mCap   <= '0;
                if (nb == 0) mRspData <= '0;
            end else begin
                mReady <= 1'b1;
            end
        end else begin
            kn = mK + 1;
            if (kn <= 2 * CD * mB) begin
                bn = (kn - 1) / (2 * CD);
                pn = (kn - 1) % (2 * CD);
                if (pn == CD && bn >= mSh && bn < mSh + mNs) mCap[bn - mSh] <= tdo;
            end
            if (kn == 2 * CD * mB + 1) mRspData <= mCap;
            if (kn == 2 * CD * mB + 2) begin
                mBusy  <= 1'b0;
                mReady <= 1'b1;
                mK     <= 0;
            end else begin
                mK <= kn;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        logic eTck, eTms, eTdi, eRv;
        int tot, bi, ph;
        if (modelOn) begin
            eTck = 1'b0; eTms = 1'b0; eTdi = 1'b0; eRv = 1'b0;
            if (mBusy) begin
                tot = 2 * CD * mB;
                if (mK <= tot) begin
                    bi = (mK - 1) / (2 * CD);
                    ph = (mK - 1) % (2 * CD);
                    eTck = (ph >= CD);
                    eTms = mTms[bi];
                    eTdi = mTdi[bi];
                end else if (mK == tot + 1) begin
                    eRv = 1'b1;
                end
            end
            checkOutput("model_cmd_ready", cmdReady, mReady);
            checkOutput("model_jtag_clk", tck, eTck);
            checkOutput("model_jtag_mode", tms, eTms);
            checkOutput("model_jtag_tdi", tdi, eTdi);
            checkOutput("model_rsp_valid", rspValid, eRv);
            checkOutput("model_rsp_data", rspData, mRspData);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] packQ(input bit q[$]);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic waitReady(input string name);
        int g;
        g = 0;
        while (cmdReady !== 1'b1 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 2000) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitRsp(input string name, output int tRsp, output logic [31:0] rd);
        int g;
        g = 0;
        while (rspValid !== 1'b1 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 2000) checkOutput({name, "_rsp_timeout"}, 32'd0, 32'd1);
        tRsp = cyc;
        rd = rspData;
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [5:0] len,
                                 input logic [31:0] data, output int tAcc, output int tRsp,
                                 output logic [31:0] rd);
        @(negedge clock);
        tmsRise.delete();
        tdiRise.delete();
        cmdValid = 1'b1;
        cmdOp = op;
        cmdLen = len;
        cmdData = data;
        waitReady(name);
        tAcc = cyc;
        @(negedge clock);
        cmdValid = 1'b0;
        waitRsp(name, tRsp, rd);
    endtask

    initial begin
        int ta, tr, g, pulses;
        logic [31:0] rd;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_cmd_ready", cmdReady, 32'd0);
        checkOutput("reset_rsp_valid", rspValid, 32'd0);
        checkOutput("reset_rsp_data", rspData, 32'd0);
        checkOutput("reset_jtag_clk", tck, 32'd0);
        checkOutput("reset_jtag_mode", tms, 32'd0);
        checkOutput("reset_jtag_tdi", tdi, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ready_after_reset", cmdReady, 32'd1);

        // IDCODE read
        applyStimulus("tlr", 2'd0, 6'd0, 32'd0, ta, tr, rd);
        checkOutput("tlr_rises", tmsRise.size(), 32'd6);
        checkOutput("tlr_tms", packQ(tmsRise), 32'b011111);
        checkOutput("tlr_latency", tr - ta, 32'd25);
        checkOutput("tlr_rsp", rd, 32'd0);
        applyStimulus("ir_idcode", 2'd1, 6'd4, 32'h0, ta, tr, rd);
        checkOutput("ir_capture", rd[1:0], 32'b01);
        applyStimulus("dr_idcode", 2'd2, 6'd32, 32'h0, ta, tr, rd);
        checkOutput("idcode", rd, IDCODE);
        checkOutput("idcode_rises", tmsRise.size(), 32'd37);

        // BYPASS
        applyStimulus("tlr2", 2'd0, 6'd0, 32'd0, ta, tr, rd);
        applyStimulus("ir_bypass", 2'd1, 6'd4, 32'hF, ta, tr, rd);
        applyStimulus("dr_bypass", 2'd2, 6'd4, 32'b1010, ta, tr, rd);
        checkOutput("bypass_data", rd, 32'h4);
        checkOutput("dr4_rises", tmsRise.size(), 32'd9);
        checkOutput("dr4_latency", tr - ta, 32'd37);
        @(negedge clock);
        checkOutput("dr4_ready_after", cmdReady, 32'd1);

        // Zero-length DR scan and IDLE N=0
        applyStimulus("dr_zero", 2'd2, 6'd0, 32'hFFFF_FFFF, ta, tr, rd);
        checkOutput("dr0_rises", tmsRise.size(), 32'd5);
        checkOutput("dr0_tms", packQ(tmsRise), 32'b01101);
        checkOutput("dr0_tdi", packQ(tdiRise), 32'd0);
        checkOutput("dr0_rsp", rd, 32'd0);
        applyStimulus("idle_zero", 2'd3, 6'd0, 32'd0, ta, tr, rd);
        checkOutput("idle0_latency", tr - ta, 32'd1);
        checkOutput("idle0_rises", tmsRise.size(), 32'd0);
        applyStimulus("idle_five", 2'd3, 6'd5, 32'hFFFF_FFFF, ta, tr, rd);
        checkOutput("idle5_rises", tmsRise.size(), 32'd5);
        checkOutput("idle5_tms", packQ(tmsRise), 32'd0);

        // Clamp
        applyStimulus("dr_clamp", 2'd2, 6'd40, 32'hA5A5_0F0F, ta, tr, rd);
        checkOutput("clamp_rises", tmsRise.size(), 32'd37);
        checkOutput("clamp_latency", tr - ta, 32'd149);

        // Back-to-back with cmd_valid held high
        @(negedge clock);
        cmdValid = 1'b1;
        cmdOp = 2'd2;
        cmdLen = 6'd4;
        cmdData = 32'h3;
        waitReady("b2b_first");
        @(negedge clock);
        cmdOp = 2'd0;
        cmdLen = 6'd0;
        waitRsp("b2b_first", tr, rd);
        @(negedge clock);
        checkOutput("b2b_ready", cmdReady, 32'd1);
        @(negedge clock);
        checkOutput("b2b_accepted", cmdReady, 32'd0);
        cmdValid = 1'b0;
        ta = cyc - 1;
        waitRsp("b2b_second", tr, rd);
        checkOutput("b2b_second_latency", tr - ta, 32'd25);

        // Reset during shift bit 10 of a 32-bit DR scan
        applyStimulus("tlr3", 2'd0, 6'd0, 32'd0, ta, tr, rd);
        applyStimulus("ir_idcode2", 2'd1, 6'd4, 32'h0, ta, tr, rd);
        @(negedge clock);
        tmsRise.delete();
        cmdValid = 1'b1;
        cmdOp = 2'd2;
        cmdLen = 6'd32;
        cmdData = 32'h0;
        waitReady("abort");
        @(negedge clock);
        cmdValid = 1'b0;
        g = 0;
        while (tmsRise.size() < 14 && g < 500) begin
            @(negedge clock);
            g++;
        end
        if (g >= 500) checkOutput("abort_reach_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_jtag_clk", tck, 32'd0);
        checkOutput("abort_jtag_mode", tms, 32'd0);
        checkOutput("abort_jtag_tdi", tdi, 32'd0);
        checkOutput("abort_rsp_valid", rspValid, 32'd0);
        checkOutput("abort_rsp_data", rspData, 32'd0);
        checkOutput("abort_cmd_ready", cmdReady, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (rspValid === 1'b1) pulses++;
        end
        checkOutput("abort_no_rsp", pulses, 32'd0);
        applyStimulus("tlr4", 2'd0, 6'd0, 32'd0, ta, tr, rd);
        applyStimulus("ir_idcode3", 2'd1, 6'd4, 32'h0, ta, tr, rd);
        applyStimulus("dr_idcode3", 2'd2, 6'd32, 32'h0, ta, tr, rd);
        checkOutput("idcode_after_abort", rd, IDCODE);

        // Random traffic, including commands offered while busy and rare resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            cmdValid = ($urandom_range(0, 2) == 0);
            cmdOp = 2'($urandom_range(0, 3));
            cmdLen = 6'($urandom_range(0, 63));
            cmdData = $urandom;
            reset = ($urandom_range(0, 799) == 0);
        end
        @(negedge clock);
        cmdValid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        waitReady("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
